// File: rtl/led_output_pkg.sv
// Shared definitions for the LED output driver: mode encodings, lamp-test
// FSM states and the default lamp bit positions.
package led_output_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_FLASH  = 2'b01;
  localparam logic [1:0] MODE_TEST   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  localparam int unsigned HRED    = 6;
  localparam int unsigned HYELLOW = 5;
  localparam int unsigned HLEFT   = 4;
  localparam int unsigned HGREEN  = 3;
  localparam int unsigned FRED    = 2;
  localparam int unsigned FYELLOW = 1;
  localparam int unsigned FLEFT   = 0;

  typedef enum logic [1:0] {
    TIdle,
    TWalk,
    TAll,
    TDone
  } test_state_e;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running divider: blink_phase toggles every BLINK_DIV cycles; tick marks
// the terminal count so callers can align with the toggle.
module blink_prescaler #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic blink_phase,
  output logic tick
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BLINK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  assign tick        = (cnt_q == LastCnt);
  assign blink_phase = phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CntW'(1);
      phase_q <= phase_q ^ tick;
    end
  end

endmodule

// File: rtl/led_output_driver.sv
// Maps traffic-light lamp requests to registered board LEDs with per-lamp
// blinking, fault flash, a walking-one lamp test, an all-off mode and a heartbeat.
module led_output_driver
  import led_output_pkg::*;
#(
  parameter int unsigned          NUM_LAMPS  = 7,
  parameter int unsigned          BLINK_DIV  = 25000000,
  parameter int unsigned          TEST_STEP  = 12500000,
  parameter logic [NUM_LAMPS-1:0] FLASH_MASK = 7'b0100010
) (
  input  logic                 CLOCK,
  input  logic                 RESETN,
  input  logic [1:0]           MODE,
  input  logic [NUM_LAMPS-1:0] LAMP_IN,
  input  logic [NUM_LAMPS-1:0] BLINK_EN,
  output logic [NUM_LAMPS:0]   LED,
  output logic                 TEST_DONE
);

  localparam int unsigned IdxW  = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;
  localparam int unsigned StepW = (TEST_STEP > 1) ? $clog2(TEST_STEP) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_LAMPS - 1);
  localparam logic [StepW-1:0] LastStep = StepW'(TEST_STEP - 1);

  logic blink_phase;
  logic unused_blink_tick;

  blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk         (CLOCK),
    .rst_n       (RESETN),
    .blink_phase (blink_phase),
    .tick        (unused_blink_tick)
  );

  test_state_e          state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [NUM_LAMPS:0]   led_q, led_d;
  logic                 done_q, done_d;
  logic [NUM_LAMPS-1:0] lamps;

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state_q <= TIdle;
      idx_q   <= '0;
      step_q  <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // Leaving lamp-test mode for even one cycle aborts the sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    if (MODE != MODE_TEST) begin
      state_d = TIdle;
      idx_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        TIdle: begin
          state_d = TWalk;
          idx_d   = '0;
          step_d  = '0;
        end
        TWalk: begin
          if (step_q == LastStep) begin
            step_d = '0;
            if (idx_q == LastIdx) state_d = TAll;
            else                  idx_d   = idx_q + IdxW'(1);
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        TAll: begin
          if (step_q == LastStep) begin
            step_d  = '0;
            state_d = TDone;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        TDone:   state_d = TDone;
        default: state_d = TIdle;
      endcase
    end
  end

  // Test patterns follow the next state so the walk shows on the entry edge.
  always_comb begin
    lamps = '0;
    unique case (MODE)
      MODE_NORMAL: lamps = LAMP_IN & (~BLINK_EN | {NUM_LAMPS{blink_phase}});
      MODE_FLASH:  lamps = FLASH_MASK & {NUM_LAMPS{blink_phase}};
      MODE_TEST: begin
        if (state_d == TWalk)                        lamps = NUM_LAMPS'(1) << idx_d;
        else if (state_d == TAll || state_d == TDone) lamps = '1;
      end
      MODE_OFF:    lamps = '0;
      default:     lamps = '0;
    endcase
    led_d  = {blink_phase, lamps};
    done_d = (state_d == TDone);
  end

  assign LED       = led_q;
  assign TEST_DONE = done_q;

endmodule

// File: tb/tb_led_output_driver.sv
// Randomized and directed bench for led_output_driver against a cycle-count
// based reference model.
module tb_led_output_driver;
  import led_output_pkg::*;

  localparam int unsigned N  = 7;
  localparam int unsigned BD = 4;
  localparam int unsigned TS = 3;
  localparam logic [N-1:0] FLASH = 7'b0100010;

  logic         CLOCK = 1'b0;
  logic         RESETN;
  logic [1:0]   MODE;
  logic [N-1:0] LAMP_IN;
  logic [N-1:0] BLINK_EN;
  logic [N:0]   LED;
  logic         TEST_DONE;

  int n_vec = 0;
  int n_err = 0;
  int n_edges = 0;   // edges since reset release
  int test_run = 0;  // consecutive edges with MODE == test

  led_output_driver #(
    .NUM_LAMPS  (N),
    .BLINK_DIV  (BD),
    .TEST_STEP  (TS),
    .FLASH_MASK (FLASH)
  ) dut (
    .CLOCK     (CLOCK),
    .RESETN    (RESETN),
    .MODE      (MODE),
    .LAMP_IN   (LAMP_IN),
    .BLINK_EN  (BLINK_EN),
    .LED       (LED),
    .TEST_DONE (TEST_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Advance one edge, update the model from the sampled inputs, compare.
  task automatic step();
    int           ph;
    int           p;
    logic [N-1:0] lamps;
    logic         done;
    @(posedge CLOCK);
    #1;
    lamps = '0;
    done  = 1'b0;
    if (!RESETN) begin
      n_edges  = 0;
      test_run = 0;
      check("led_reset", 32'(LED), 32'h0);
      check("done_reset", 32'(TEST_DONE), 32'h0);
      return;
    end
    ph = (n_edges / BD) % 2;
    n_edges++;
    test_run = (MODE == MODE_TEST) ? test_run + 1 : 0;
    case (MODE)
      MODE_NORMAL: for (int i = 0; i < N; i++) lamps[i] = LAMP_IN[i] && (!BLINK_EN[i] || ph == 1);
      MODE_FLASH:  for (int i = 0; i < N; i++) lamps[i] = FLASH[i] && ph == 1;
      MODE_TEST: begin
        p = test_run - 1;
        if (p < N * TS) lamps[p / TS] = 1'b1;
        else            lamps = '1;
        done = (p >= (N + 1) * TS);
      end
      default: lamps = '0;
    endcase
    check($sformatf("led_mode%0d", MODE), 32'(LED), 32'({ph[0], lamps}));
    check($sformatf("done_mode%0d", MODE), 32'(TEST_DONE), 32'(done));
  endtask

  task automatic run(input logic [1:0] m, input int cycles);
    MODE = m;
    repeat (cycles) step();
  endtask

  initial begin
    int len;
    RESETN   = 1'b0;
    MODE     = MODE_NORMAL;
    LAMP_IN  = 7'h7F;
    BLINK_EN = 7'h00;
    repeat (3) step();
    RESETN = 1'b1;
    step();
    check("first_after_release", 32'(LED), 32'h7F);

    LAMP_IN  = 7'b0100100;
    BLINK_EN = 7'b0100000;
    run(MODE_NORMAL, 12);

    LAMP_IN = 7'h7F;
    run(MODE_FLASH, 12);

    run(MODE_TEST, N * TS + TS + 5);
    check("test_done_held", 32'(TEST_DONE), 32'h1);
    run(MODE_NORMAL, 2);

    run(MODE_TEST, 3 * TS + 1);
    run(MODE_OFF, 1);
    check("abort_off", 32'(LED[N-1:0]), 32'h0);
    run(MODE_TEST, 2);
    check("restart_walk", 32'(LED[N-1:0]), 32'h01);
    run(MODE_TEST, 5);

    run(MODE_NORMAL, 1);
    run(MODE_TEST, N * TS + 1);
    RESETN = 1'b0;
    repeat (2) step();
    RESETN = 1'b1;
    step();
    check("walk_after_reset", 32'(LED[N-1:0]), 32'h01);
    run(MODE_TEST, 4);

    repeat (60) begin
      MODE = 2'($urandom_range(3));
      len  = $urandom_range(1, 40);
      repeat (len) begin
        LAMP_IN  = N'($urandom);
        BLINK_EN = N'($urandom);
        RESETN   = ($urandom_range(199) != 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_output_driver.md
Name: led_output_driver

Overview:
- Parametrised successor to the fixed 8-bit lamp-to-LED mapper for the traffic light controller.
- Drives NUM_LAMPS lamp LEDs plus a heartbeat LED on the MSB.
- Adds registered outputs, per-lamp blinking, a fault flash mode, a walking-one lamp test and an all-off mode.
- Sits between the traffic light controller FSM outputs and the board LED pins.

Parameters:
- NUM_LAMPS, 7: number of lamp channels. Must be >= 1.
- BLINK_DIV, 25000000: CLOCK cycles per blink half-period. Must be >= 2.
- TEST_STEP, 12500000: CLOCK cycles each lamp-test step lasts. Must be >= 1.
- FLASH_MASK, 7'b0100010: lamps lit in flash mode (default: HYELLOW bit 5, FYELLOW bit 1). Width is NUM_LAMPS.

Ports:
- CLOCK  in  1  system clock.
- RESETN  in  1  reset, synchronous, active-low.
- MODE  in  2  operating mode: 00 NORMAL, 01 FLASH, 10 LAMP_TEST, 11 OFF.
- LAMP_IN  in  NUM_LAMPS  lamp requests; bit order is HRED, HYELLOW, HLEFT, HGREEN, FRED, FYELLOW, FLEFT from MSB to LSB at default width.
- BLINK_EN  in  NUM_LAMPS  per-lamp blink enable, used in NORMAL mode.
- LED  out  NUM_LAMPS+1  LED[NUM_LAMPS] is the heartbeat; LED[i] drives lamp i.
- TEST_DONE  out  1  high while the lamp test is complete and MODE is still LAMP_TEST.

Behaviour:
- Reset (RESETN=0 sampled at a CLOCK edge):
  - LED=0, TEST_DONE=0.
  - Blink counter=0, blink_phase=0.
  - Test FSM returns to T_IDLE; step counter=0, lamp index=0.
  - Reset mid-test aborts the test.
- Blink prescaler:
  - Counter runs 0..BLINK_DIV-1 and wraps to 0.
  - blink_phase toggles on the edge where count==BLINK_DIV-1.
  - Full blink period is 2*BLINK_DIV cycles.
  - Runs in every mode and is never reset by mode changes.
  - Counter width is $clog2(BLINK_DIV).
- All outputs are registered. Latency from inputs or blink_phase to LED is 1 cycle.
- LED[NUM_LAMPS] = blink_phase in all modes.
- NORMAL: LED[i] = LAMP_IN[i] & (~BLINK_EN[i] | blink_phase).
- FLASH: LED[i] = FLASH_MASK[i] & blink_phase. LAMP_IN and BLINK_EN are ignored.
- OFF: lamp LEDs = 0; heartbeat still toggles.
- LAMP_TEST FSM states: T_IDLE, T_WALK, T_ALL, T_DONE.
  - T_IDLE -> T_WALK on the first cycle MODE==10. Step counter=0, index=0.
  - T_WALK: only LED[index] is on. The step counter counts 0..TEST_STEP-1. At terminal count the step counter clears and index increments. At terminal count with index==NUM_LAMPS-1, go to T_ALL instead.
  - T_ALL: all lamp LEDs on for TEST_STEP cycles, then go to T_DONE.
  - T_DONE: all lamp LEDs on, TEST_DONE=1, held while MODE stays 10.
  - Any cycle with MODE!=10 returns the FSM to T_IDLE (abort included) and clears TEST_DONE on the next edge.
  - Re-entering LAMP_TEST restarts from index 0.
- Mode changes take effect on the next edge. No glitch or blank cycle is inserted.
- Simultaneous blink toggle and mode change: the new mode is evaluated with the new phase value, since both update on the same edge. The LED shows the result one cycle later.

Decomposition:
- Shared package led_output_pkg holds:
  - mode encodings MODE_NORMAL, MODE_FLASH, MODE_TEST, MODE_OFF;
  - test FSM state typedef;
  - default lamp bit-index constants (HRED..FLEFT).
- Sub-module blink_prescaler (parameter BLINK_DIV; outputs blink_phase plus a one-cycle tick). It is reused by the controller's timing logic.

Test Plan (NUM_LAMPS=7, BLINK_DIV=4, TEST_STEP=3):
- Reset: hold RESETN=0 for 3 cycles with LAMP_IN=7'h7F -> LED=8'h00 and TEST_DONE=0 throughout. On the first edge after release, LED=8'h7F (phase 0, BLINK_EN=0).
- NORMAL blink: LAMP_IN=7'b0100100, BLINK_EN=7'b0100000 -> LED[5] alternates every 4 cycles in phase with LED[7]; LED[2]=1 constant; all other bits 0.
- FLASH: MODE=01 with LAMP_IN=7'h7F -> LED[6:0] toggles between 7'b0000000 and 7'b0100010 every 4 cycles; LED[7] equals LED[5].
- LAMP_TEST full pass:
  - MODE=10 -> LED[6:0] steps through 0000001, 0000010, ... 1000000, holding each for 3 cycles.
  - Then 1111111 for 3 cycles.
  - Then TEST_DONE=1 with 1111111 held; TEST_DONE goes 0 one cycle after MODE=00.
- Abort and restart: MODE=10, switch to 11 when index=3 -> LED[6:0]=0 next cycle. MODE back to 10 -> walk restarts at 0000001.
- Reset mid-test: RESETN=0 during T_ALL -> LED=0 and TEST_DONE=0. After release with MODE=10, the walk starts from index 0.
